// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared width default, lane result encoding and the lane add function
//    HA_DEFAULT_WIDTH : default lane count for half_adder
//    ha_result_t      : {carry, sum} of one lane, carry in the MSB
//    ha_add()         : single-lane half add, the only place the lane equations live
package half_adder_pkg;

   localparam int HA_DEFAULT_WIDTH = 1;

   typedef struct packed {
      logic carry;
      logic sum;
   } ha_result_t;

   function automatic ha_result_t ha_add(input logic a, input logic b);
      return '{carry: a & b, sum: a ^ b};
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: one combinational half-adder lane
//    i_bit1, i_bit2 : operand bits
//    o_carry        : i_bit1 & i_bit2
//    o_sum          : i_bit1 ^ i_bit2
module half_adder_cell
   import half_adder_pkg::*;
(
   input  logic i_bit1,
   input  logic i_bit2,
   output logic o_carry,
   output logic o_sum
);

   ha_result_t w_res;

   assign w_res   = ha_add(i_bit1, i_bit2);
   assign o_carry = w_res.carry;
   assign o_sum   = w_res.sum;

endmodule

// File: rtl/half_adder.sv
// half_adder: WIDTH-lane bitwise half adder with a zero-latency path and a registered valid-qualified path
//    clk                : rising-edge clock for the registered path
//    rst_n              : asynchronous active-low reset, clears the registered path
//    i_bit1, i_bit2     : operands, WIDTH lanes
//    i_in_valid         : qualifies operands for capture
//    o_carry, o_sum     : combinational per-lane carry/sum
//    o_carry_q, o_sum_q : registered carry/sum, held while no valid input arrives
//    o_out_valid        : registered outputs carry a result captured on the previous cycle
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_bit1,
   input  logic [WIDTH-1:0] i_bit2,
   input  logic             i_in_valid,
   output logic [WIDTH-1:0] o_carry,
   output logic [WIDTH-1:0] o_sum,
   output logic [WIDTH-1:0] o_carry_q,
   output logic [WIDTH-1:0] o_sum_q,
   output logic             o_out_valid
);

   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_valid;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         half_adder_cell u_cell (
            .i_bit1 (i_bit1[i]),
            .i_bit2 (i_bit2[i]),
            .o_carry(w_carry[i]),
            .o_sum  (w_sum[i])
         );
      end
   endgenerate

   // Both paths share the lane outputs so they can never disagree.
   assign o_carry = w_carry;
   assign o_sum   = w_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry <= '0;
         r_sum   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_in_valid;
         if (i_in_valid) begin
            r_carry <= w_carry;
            r_sum   <= w_sum;
         end
      end
   end

   assign o_carry_q   = r_carry;
   assign o_sum_q     = r_sum;
   assign o_out_valid = r_valid;

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: self-checking bench for half_adder at WIDTH=1 and WIDTH=8
module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [0:0] a1 = '0, b1 = '0, c1, s1, cq1, sq1;
   logic       v1i = 1'b0, v1o;
   logic [7:0] a8 = '0, b8 = '0, c8, s8, cq8, sq8;
   logic       v8i = 1'b0, v8o;

   int total = 0;
   int bad = 0;

   logic [15:0] q[$];
   logic        pend = 1'b0;
   logic [7:0]  hold_c = '0, hold_s = '0;

   always #5 clk = ~clk;

   half_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .i_bit1(a1), .i_bit2(b1), .i_in_valid(v1i),
      .o_carry(c1), .o_sum(s1), .o_carry_q(cq1), .o_sum_q(sq1), .o_out_valid(v1o)
   );

   half_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .i_bit1(a8), .i_bit2(b8), .i_in_valid(v8i),
      .o_carry(c8), .o_sum(s8), .o_carry_q(cq8), .o_sum_q(sq8), .o_out_valid(v8o)
   );

   task automatic reset_model();
      q.delete();
      pend   = 1'b0;
      hold_c = '0;
      hold_s = '0;
   endtask

   // Drive the 8-lane DUT, push the expected registered result, and check the combinational path.
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v);
      a8  = a;
      b8  = b;
      v8i = v;
      pend = v && rst_n;
      if (pend) q.push_back({a & b, a ^ b});
      #1;
      total++;
      if ({c8, s8} !== {a & b, a ^ b}) begin
         bad++;
         $display("FAIL comb8 a=%h b=%h: got c=%h s=%h want c=%h s=%h", a, b, c8, s8, a & b, a ^ b);
      end
   endtask

   // Advance one edge and compare the registered 8-lane path against the scoreboard.
   task automatic tick8(input string nm);
      @(posedge clk);
      #1;
      if (pend) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
         end else begin
            {hold_c, hold_s} = q.pop_front();
         end
      end
      total++;
      if ({v8o, cq8, sq8} !== {pend, hold_c, hold_s}) begin
         bad++;
         $display("FAIL %s: got v=%b cq=%h sq=%h want v=%b cq=%h sq=%h",
                  nm, v8o, cq8, sq8, pend, hold_c, hold_s);
      end
      pend = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      reset_model();
      #1;
      total++;
      if ({v1o, cq1, sq1} !== 3'b000) begin
         bad++;
         $display("FAIL reset_u1: got v=%b cq=%b sq=%b want 0 0 0", v1o, cq1, sq1);
      end
      total++;
      if ({v8o, cq8, sq8} !== 17'h0) begin
         bad++;
         $display("FAIL reset_u8: got v=%b cq=%h sq=%h want 0 00 00", v8o, cq8, sq8);
      end
   endtask

   // Combinational truth table runs while reset is still asserted: it must not matter.
   task automatic test_comb();
      logic [1:0] exp_cs[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
      for (int k = 0; k < 4; k++) begin
         {a1, b1} = 2'(k);
         #10;
         total++;
         if ({c1, s1} !== exp_cs[k]) begin
            bad++;
            $display("FAIL comb1 in=%b: got %b want %b", 2'(k), {c1, s1}, exp_cs[k]);
         end
      end
      drive8(8'hFF, 8'hFF, 1'b0);
      drive8(8'h00, 8'h00, 1'b0);
      drive8(8'hA5, 8'h5A, 1'b0);
      total++;
      if ({c8, s8} !== 16'h00FF) begin
         bad++;
         $display("FAIL comb8_a55a: got c=%h s=%h want 00 FF", c8, s8);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(posedge clk);
      #1;
      a1 = 1'b1; b1 = 1'b1; v1i = 1'b1;
      @(posedge clk);
      #1;
      v1i = 1'b0; a1 = 1'b0;
      total++;
      if ({v1o, cq1, sq1} !== 3'b110) begin
         bad++;
         $display("FAIL single_cap: got v=%b cq=%b sq=%b want 1 1 0", v1o, cq1, sq1);
      end
      @(posedge clk);
      #1;
      total++;
      if ({v1o, cq1, sq1} !== 3'b010) begin
         bad++;
         $display("FAIL single_hold: got v=%b cq=%b sq=%b want 0 1 0", v1o, cq1, sq1);
      end
   endtask

   task automatic test_async_reset();
      a1 = 1'b1; b1 = 1'b1; v1i = 1'b1;
      @(posedge clk);
      #1;
      v1i = 1'b0;
      total++;
      if ({v1o, cq1} !== 2'b11) begin
         bad++;
         $display("FAIL areset_pre: got v=%b cq=%b want 1 1", v1o, cq1);
      end
      #2 rst_n = 1'b0;
      reset_model();
      #1;
      total++;
      if ({v1o, cq1, sq1} !== 3'b000) begin
         bad++;
         $display("FAIL areset_clear: got v=%b cq=%b sq=%b want 0 0 0", v1o, cq1, sq1);
      end
      a1 = 1'b0;
      #1;
      total++;
      if ({c1, s1} !== 2'b01) begin
         bad++;
         $display("FAIL areset_comb: got c=%b s=%b want 0 1", c1, s1);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] ea[3] = '{8'hFF, 8'hA5, 8'h00};
      logic [7:0] eb[3] = '{8'hFF, 8'h5A, 8'h00};
      logic [15:0] er[3] = '{16'hFF00, 16'h00FF, 16'h0000};
      @(posedge clk);
      #1;
      drive8(ea[0], eb[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick8("b2b_sb");
         total++;
         if ({v8o, cq8, sq8} !== {1'b1, er[k]}) begin
            bad++;
            $display("FAIL b2b_%0d: got v=%b cq=%h sq=%h want 1 %h", k, v8o, cq8, sq8, er[k]);
         end
         if (k < 2) drive8(ea[k+1], eb[k+1], 1'b1);
         else drive8(8'h3C, 8'hC3, 1'b0);
      end
      tick8("b2b_idle");
   endtask

   task automatic test_random();
      for (int k = 0; k < 1000; k++) begin
         drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         tick8("rand");
      end
   endtask

   task automatic test_reset_pulse();
      drive8(8'h3C, 8'h0F, 1'b1);
      #2 rst_n = 1'b0;
      reset_model();
      #1;
      total++;
      if (v8o !== 1'b0) begin
         bad++;
         $display("FAIL pulse_clear: got v=%b want 0", v8o);
      end
      @(posedge clk);
      #1;
      total++;
      if ({v8o, cq8, sq8} !== 17'h0) begin
         bad++;
         $display("FAIL pulse_held: got v=%b cq=%h sq=%h want 0 00 00", v8o, cq8, sq8);
      end
      @(negedge clk);
      v8i = 1'b0;
      rst_n = 1'b1;
      tick8("pulse_release");
      drive8(8'h12, 8'h34, 1'b1);
      tick8("pulse_first");
      total++;
      if ({v8o, cq8, sq8} !== {1'b1, 8'h10, 8'h26}) begin
         bad++;
         $display("FAIL pulse_data: got v=%b cq=%h sq=%h want 1 10 26", v8o, cq8, sq8);
      end
   endtask

   initial begin
      test_reset();
      test_comb();
      test_single();
      test_async_reset();
      test_back_to_back();
      test_random();
      test_reset_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bitwise half adder over WIDTH independent lanes. Each lane adds bit1[i] + bit2[i] and produces sum[i] (XOR) and carry[i] (AND).
- Provides two result paths:
  - combinational outputs with zero latency, for use in glue logic;
  - a registered, valid-qualified copy with one-cycle latency, for pipelined datapaths.
- Leaf arithmetic block, instantiated wherever single-bit-pair addition without carry-in is needed.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (WIDTH >= 1).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset; clears the registered path.
- carry  output  WIDTH  combinational carry per lane, carry[i] = bit1[i] & bit2[i].
- sum  output  WIDTH  combinational sum per lane, sum[i] = bit1[i] ^ bit2[i].
- bit1  input  WIDTH  first operand bits.
- bit2  input  WIDTH  second operand bits.
- in_valid  input  1  qualifies bit1/bit2 for capture into the registered path.
- carry_q  output  WIDTH  registered carry.
- sum_q  output  WIDTH  registered sum.
- out_valid  output  1  carry_q/sum_q hold a result captured on the previous valid cycle.

Behaviour:
- Combinational path
  - carry/sum depend only on bit1/bit2; zero latency.
  - Unaffected by clk, rst_n and in_valid.
  - Per-lane truth table (bit1, bit2 -> carry, sum): 00->00, 01->01, 10->01, 11->10.
  - {carry[i],sum[i]} always equals the 2-bit value bit1[i]+bit2[i]. No inter-lane carry propagation.
- Registered path
  - rst_n low: carry_q, sum_q and out_valid go to 0 immediately, without waiting for a clock edge.
  - rst_n deassertion is synchronised externally; the block needs no internal synchroniser.
  - Rising clk with in_valid=1: carry_q<=bit1&bit2, sum_q<=bit1^bit2, out_valid<=1.
  - Rising clk with in_valid=0: carry_q/sum_q hold their value, out_valid<=0.
  - Latency is exactly 1 cycle. Throughput is one result per cycle. There is no backpressure.
  - Reset asserted mid-stream discards the in-flight result; the first valid input after release appears one cycle later.
  - Back-to-back valids produce back-to-back out_valid with the matching data.
- Boundary cases
  - All-ones operands: carry=all ones, sum=0.
  - All-zeros operands: carry=0, sum=0.
  - X/Z on inputs is not sanitised.
- Implementation
  - No latches. Combinational outputs are driven from the same lane logic as the register inputs, so both paths always agree for the same operands.

Decomposition:
- Package half_adder_pkg: constant HA_DEFAULT_WIDTH = 1, and the lane result encoding {carry,sum} as a 2-bit typedef ha_result_t.
- Sub-module half_adder_cell: 1-bit combinational lane (bit1, bit2 -> carry, sum).
  - Instantiated WIDTH times via generate.
  - Top level adds the register stage and valid tracking.

Test Plan:
- WIDTH=1, rst_n held high, no clock needed; apply bit1/bit2 = 00, 01, 10, 11 at 10 ns intervals -> carry,sum = 00, 01, 01, 10, each settled within the same time step.
- Assert rst_n=0 asynchronously between edges while carry_q=1 and out_valid=1 -> carry_q, sum_q and out_valid read 0 before the next edge. Combinational carry/sum continue to track the inputs during reset.
- WIDTH=1, in_valid=1 for one cycle with bit1=1, bit2=1, then in_valid=0 -> next cycle carry_q=1, sum_q=0, out_valid=1. Following cycle out_valid=0 and carry_q/sum_q unchanged.
- WIDTH=8, back-to-back valid operands (0xFF,0xFF), (0xA5,0x5A), (0x00,0x00) -> registered outputs one cycle later, consecutively:
  - carry_q/sum_q = 0xFF/0x00
  - carry_q/sum_q = 0x00/0xFF
  - carry_q/sum_q = 0x00/0x00
  - out_valid high for 3 consecutive cycles.
- WIDTH=8, random operands with in_valid toggled randomly over 1000 cycles -> every cycle carry==bit1&bit2 and sum==bit1^bit2. Registered outputs match the scoreboard with 1-cycle delay and hold during invalid cycles.
- Reset pulse while in_valid=1 -> no out_valid the cycle after reset release unless in_valid is sampled high at a post-release edge.
